// File: rtl/prog_mod_counter_if.sv
// Control/status bundle for prog_mod_counter: the master drives the controls,
// the slave (counter) returns count, modulus and strobes.
interface prog_mod_counter_if #(
    parameter int N = 8
) ();
    logic         en;
    logic         dir;
    logic         oneshot;
    logic         start;
    logic         m_load;
    logic [N-1:0] m_in;
    logic [N-1:0] q;
    logic [N-1:0] m_cur;
    logic         max_tick;
    logic         busy;

    modport master (
        output en, dir, oneshot, start, m_load, m_in,
        input  q, m_cur, max_tick, busy
    );

    modport slave (
        input  en, dir, oneshot, start, m_load, m_in,
        output q, m_cur, max_tick, busy
    );
endinterface

// File: rtl/prog_mod_counter.sv
// Runtime-programmable mod-M up/down counter with one-shot mode and restart.
// Optional prescaler enabled by defining PROG_MOD_COUNTER_PRESCALE_EN.
module prog_mod_counter #(
    parameter int N       = 8,
    parameter int M_RESET = 10,
    parameter int P       = 4
) (
    input  logic                clk,
    input  logic                reset,
    prog_mod_counter_if.slave   bus
);

    typedef enum logic {
        RUN  = 1'b0,
        STOP = 1'b1
    } state_t;

    localparam logic [N-1:0] ONE     = N'(1);
    // A modulus of 2^N truncates to a stored 0; m_reg - 1 then wraps to 2^N - 1.
    localparam logic [N-1:0] M_RST_V = N'(M_RESET);

    if (P < 1 || M_RESET < 1 || M_RESET > (2 ** N)) begin : g_param_check
        $error("prog_mod_counter: parameter out of range");
    end

    state_t       state, state_next;
    logic [N-1:0] q, q_next;
    logic [N-1:0] m_reg, m_next;
    logic [N-1:0] m_new;
    logic [N-1:0] term_v;
    logic [N-1:0] start_v;
    logic         adv;
    logic         step;
    logic         at_term;

`ifdef PROG_MOD_COUNTER_PRESCALE_EN
    localparam int           PW      = (P > 1) ? $clog2(P) : 1;
    localparam logic [PW-1:0] PC_LAST = PW'(P - 1);
    logic [PW-1:0] pc, pc_next;

    assign step = adv && (pc == PC_LAST);
`else
    assign step = adv;
`endif

    assign adv     = bus.en && (state == RUN);
    assign term_v  = bus.dir ? '0 : m_reg - ONE;
    assign start_v = bus.dir ? m_reg - ONE : '0;
    assign at_term = (q == term_v);
    assign m_new   = (bus.m_in == '0) ? ONE : bus.m_in;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path leaves it unassigned and infers a latch.
        state_next = state;
        q_next     = q;
        m_next     = m_reg;
`ifdef PROG_MOD_COUNTER_PRESCALE_EN
        pc_next    = pc;
`endif
        if (bus.m_load) begin
            m_next = m_new;
            q_next = bus.dir ? m_new - ONE : '0;
`ifdef PROG_MOD_COUNTER_PRESCALE_EN
            pc_next = '0;
`endif
            if (bus.start) state_next = RUN;
        end else if (bus.start && state == STOP) begin
            state_next = RUN;
`ifdef PROG_MOD_COUNTER_PRESCALE_EN
            pc_next = '0;
`endif
        end else begin
`ifdef PROG_MOD_COUNTER_PRESCALE_EN
            if (adv) pc_next = (pc == PC_LAST) ? '0 : pc + PW'(1);
`endif
            if (step) begin
                if (at_term) begin
                    q_next = start_v;
                    if (bus.oneshot) state_next = STOP;
                end else begin
                    q_next = bus.dir ? q - ONE : q + ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (reset) begin
            state <= RUN;
            q     <= '0;
            m_reg <= M_RST_V;
`ifdef PROG_MOD_COUNTER_PRESCALE_EN
            pc    <= '0;
`endif
        end else begin
            state <= state_next;
            q     <= q_next;
            m_reg <= m_next;
`ifdef PROG_MOD_COUNTER_PRESCALE_EN
            pc    <= pc_next;
`endif
        end
    end

    // Load cycles never produce a tick; reset masks the strobe immediately.
    assign bus.max_tick = !reset && !bus.m_load && step && at_term;
    assign bus.q        = q;
    assign bus.m_cur    = m_reg;
    assign bus.busy     = (state == RUN);

endmodule

// File: tb/tb_prog_mod_counter.sv
// Directed self-checking bench for prog_mod_counter (M_RESET=10, plus a
// 2^N-modulus instance); prescaler scenario runs when the macro is defined.
module tb_prog_mod_counter;

    localparam int N = 8;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    prog_mod_counter_if #(.N(N)) bus  ();
    prog_mod_counter_if #(.N(N)) bus2 ();

    prog_mod_counter #(.N(N), .M_RESET(10), .P(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    prog_mod_counter #(.N(N), .M_RESET(256), .P(4)) dut_full (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.en = 0; bus.dir = 0; bus.oneshot = 0; bus.start = 0; bus.m_load = 0; bus.m_in = '0;
        bus2.en = 0; bus2.dir = 0; bus2.oneshot = 0; bus2.start = 0; bus2.m_load = 0; bus2.m_in = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        cyc();
        reset = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        bus.en = 1; bus.dir = 1;
        cyc();
        #1;
        n_cmp++; if (bus.q !== 8'd0) begin n_bad++; $display("FAIL reset_q: got %0d want 0", bus.q); end
        n_cmp++; if (bus.m_cur !== 8'd10) begin n_bad++; $display("FAIL reset_m_cur: got %0d want 10", bus.m_cur); end
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL reset_busy: got %b want 1", bus.busy); end
        n_cmp++; if (bus.max_tick !== 1'b0) begin n_bad++; $display("FAIL reset_tick_masked: got %b want 0", bus.max_tick); end
        n_cmp++; if (bus2.m_cur !== 8'd0) begin n_bad++; $display("FAIL reset_full_m_cur: got %0d want 0", bus2.m_cur); end
        reset = 0;
        #1;
        n_cmp++; if (bus.max_tick !== 1'b1) begin n_bad++; $display("FAIL reset_down_first_tick: got %b want 1", bus.max_tick); end
    endtask

    task automatic test_count_up();
        do_reset();
        bus.en = 1;
        for (int i = 0; i < 21; i++) begin
            #1;
            n_cmp++; if (bus.q !== 8'(i % 10)) begin n_bad++; $display("FAIL up_q[%0d]: got %0d want %0d", i, bus.q, i % 10); end
            n_cmp++; if (bus.max_tick !== (i % 10 == 9)) begin n_bad++; $display("FAIL up_tick[%0d]: got %b want %b", i, bus.max_tick, (i % 10 == 9)); end
            cyc();
        end
    endtask

    task automatic test_count_down();
        do_reset();
        bus.en = 1; bus.dir = 1;
        for (int i = 0; i < 21; i++) begin
            #1;
            n_cmp++; if (bus.q !== 8'((10 - i % 10) % 10)) begin n_bad++; $display("FAIL down_q[%0d]: got %0d want %0d", i, bus.q, (10 - i % 10) % 10); end
            n_cmp++; if (bus.max_tick !== (i % 10 == 0)) begin n_bad++; $display("FAIL down_tick[%0d]: got %b want %b", i, bus.max_tick, (i % 10 == 0)); end
            cyc();
        end
    endtask

    task automatic test_dir_change();
        do_reset();
        bus.en = 1;
        repeat (3) cyc();
        bus.dir = 1;
        #1;
        n_cmp++; if (bus.q !== 8'd3) begin n_bad++; $display("FAIL dirchg_hold: got %0d want 3", bus.q); end
        cyc();
        n_cmp++; if (bus.q !== 8'd2) begin n_bad++; $display("FAIL dirchg_down: got %0d want 2", bus.q); end
    endtask

    task automatic test_load();
        do_reset();
        bus.en = 1;
        repeat (7) cyc();
        bus.m_in = 8'd5; bus.m_load = 1;
        #1;
        n_cmp++; if (bus.q !== 8'd7) begin n_bad++; $display("FAIL load_pre_q: got %0d want 7", bus.q); end
        n_cmp++; if (bus.max_tick !== 1'b0) begin n_bad++; $display("FAIL load_no_tick: got %b want 0", bus.max_tick); end
        cyc();
        bus.m_load = 0;
        n_cmp++; if (bus.m_cur !== 8'd5) begin n_bad++; $display("FAIL load_m_cur: got %0d want 5", bus.m_cur); end
        for (int i = 0; i < 10; i++) begin
            #1;
            n_cmp++; if (bus.q !== 8'(i % 5)) begin n_bad++; $display("FAIL mod5_q[%0d]: got %0d want %0d", i, bus.q, i % 5); end
            n_cmp++; if (bus.max_tick !== (i % 5 == 4)) begin n_bad++; $display("FAIL mod5_tick[%0d]: got %b want %b", i, bus.max_tick, (i % 5 == 4)); end
            cyc();
        end
        // Load while sitting on the terminal value: the tick must be suppressed.
        repeat (4) cyc();
        bus.m_in = 8'd0; bus.m_load = 1;
        #1;
        n_cmp++; if (bus.q !== 8'd4) begin n_bad++; $display("FAIL load0_pre_q: got %0d want 4", bus.q); end
        n_cmp++; if (bus.max_tick !== 1'b0) begin n_bad++; $display("FAIL load0_term_no_tick: got %b want 0", bus.max_tick); end
        cyc();
        bus.m_load = 0;
        n_cmp++; if (bus.m_cur !== 8'd1) begin n_bad++; $display("FAIL load0_m_cur: got %0d want 1", bus.m_cur); end
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++; if (bus.q !== 8'd0) begin n_bad++; $display("FAIL mod1_q[%0d]: got %0d want 0", i, bus.q); end
            n_cmp++; if (bus.max_tick !== 1'b1) begin n_bad++; $display("FAIL mod1_tick[%0d]: got %b want 1", i, bus.max_tick); end
            cyc();
        end
        // Load while counting down starts from the new modulus minus one.
        bus.dir = 1; bus.m_in = 8'd6; bus.m_load = 1;
        cyc();
        bus.m_load = 0;
        n_cmp++; if (bus.q !== 8'd5) begin n_bad++; $display("FAIL load_down_q: got %0d want 5", bus.q); end
    endtask

    task automatic test_oneshot();
        do_reset();
        bus.en = 1; bus.oneshot = 1; bus.m_in = 8'd4; bus.m_load = 1;
        cyc();
        bus.m_load = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++; if (bus.q !== 8'(i)) begin n_bad++; $display("FAIL os_q[%0d]: got %0d want %0d", i, bus.q, i); end
            n_cmp++; if (bus.max_tick !== (i == 3)) begin n_bad++; $display("FAIL os_tick[%0d]: got %b want %b", i, bus.max_tick, (i == 3)); end
            n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL os_busy[%0d]: got %b want 1", i, bus.busy); end
            cyc();
        end
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (bus.q !== 8'd0) begin n_bad++; $display("FAIL stop_q[%0d]: got %0d want 0", i, bus.q); end
            n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL stop_busy[%0d]: got %b want 0", i, bus.busy); end
            n_cmp++; if (bus.max_tick !== 1'b0) begin n_bad++; $display("FAIL stop_tick[%0d]: got %b want 0", i, bus.max_tick); end
            cyc();
        end
        bus.oneshot = 0;
        cyc();
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL stop_oneshot_clear: got %b want 0", bus.busy); end
        bus.oneshot = 1; bus.start = 1;
        cyc();
        bus.start = 0;
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL start_busy: got %b want 1", bus.busy); end
        n_cmp++; if (bus.q !== 8'd0) begin n_bad++; $display("FAIL start_q: got %0d want 0", bus.q); end
        cyc();
        n_cmp++; if (bus.q !== 8'd1) begin n_bad++; $display("FAIL start_count: got %0d want 1", bus.q); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.en = 1; bus.m_in = 8'd8; bus.m_load = 1;
        cyc();
        bus.m_load = 0;
        repeat (6) cyc();
        n_cmp++; if (bus.q !== 8'd6) begin n_bad++; $display("FAIL mid_pre_q: got %0d want 6", bus.q); end
        reset = 1;
        cyc();
        reset = 0;
        bus.en = 0;
        #1;
        n_cmp++; if (bus.q !== 8'd0) begin n_bad++; $display("FAIL mid_q: got %0d want 0", bus.q); end
        n_cmp++; if (bus.m_cur !== 8'd10) begin n_bad++; $display("FAIL mid_m_cur: got %0d want 10", bus.m_cur); end
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy: got %b want 1", bus.busy); end
        n_cmp++; if (bus.max_tick !== 1'b0) begin n_bad++; $display("FAIL mid_tick: got %b want 0", bus.max_tick); end
    endtask

    task automatic test_load_start_stop();
        do_reset();
        bus.en = 1; bus.oneshot = 1; bus.m_in = 8'd2; bus.m_load = 1;
        cyc();
        bus.m_load = 0;
        repeat (2) cyc();
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL ls_stopped: got %b want 0", bus.busy); end
        bus.m_in = 8'd3; bus.m_load = 1; bus.start = 1;
        cyc();
        bus.m_load = 0; bus.start = 0;
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL ls_busy: got %b want 1", bus.busy); end
        n_cmp++; if (bus.m_cur !== 8'd3) begin n_bad++; $display("FAIL ls_m_cur: got %0d want 3", bus.m_cur); end
        n_cmp++; if (bus.q !== 8'd0) begin n_bad++; $display("FAIL ls_q0: got %0d want 0", bus.q); end
        repeat (2) cyc();
        n_cmp++; if (bus.q !== 8'd2) begin n_bad++; $display("FAIL ls_q2: got %0d want 2", bus.q); end
        n_cmp++; if (bus.max_tick !== 1'b1) begin n_bad++; $display("FAIL ls_tick: got %b want 1", bus.max_tick); end
    endtask

    task automatic test_full_modulus();
        int ticks;
        do_reset();
        ticks = 0;
        bus2.en = 1;
        for (int i = 0; i < 258; i++) begin
            #1;
            if (bus2.max_tick === 1'b1) ticks++;
            if (i == 255) begin
                n_cmp++; if (bus2.q !== 8'd255 || bus2.max_tick !== 1'b1) begin n_bad++; $display("FAIL full_term: got q=%0d tick=%b want q=255 tick=1", bus2.q, bus2.max_tick); end
            end
            cyc();
        end
        n_cmp++; if (bus2.q !== 8'd2) begin n_bad++; $display("FAIL full_wrap_q: got %0d want 2", bus2.q); end
        n_cmp++; if (ticks != 1) begin n_bad++; $display("FAIL full_tick_count: got %0d want 1", ticks); end
        bus2.en = 0;
    endtask

`ifdef PROG_MOD_COUNTER_PRESCALE_EN
    task automatic test_prescale();
        do_reset();
        bus.en = 1; bus.m_in = 8'd3; bus.m_load = 1;
        cyc();
        bus.m_load = 0;
        for (int i = 0; i < 24; i++) begin
            #1;
            n_cmp++; if (bus.q !== 8'((i / 4) % 3)) begin n_bad++; $display("FAIL pre_q[%0d]: got %0d want %0d", i, bus.q, (i / 4) % 3); end
            n_cmp++; if (bus.max_tick !== (i % 12 == 11)) begin n_bad++; $display("FAIL pre_tick[%0d]: got %b want %b", i, bus.max_tick, (i % 12 == 11)); end
            cyc();
        end
        repeat (2) cyc();
        bus.en = 0;
        repeat (5) cyc();
        bus.en = 1;
        repeat (1) cyc();
        n_cmp++; if (bus.q !== 8'd0) begin n_bad++; $display("FAIL pre_hold_q: got %0d want 0", bus.q); end
        cyc();
        n_cmp++; if (bus.q !== 8'd1) begin n_bad++; $display("FAIL pre_resume_q: got %0d want 1", bus.q); end
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1;
        idle_inputs();
        test_reset();
`ifdef PROG_MOD_COUNTER_PRESCALE_EN
        test_prescale();
`else
        test_count_up();
        test_count_down();
        test_dir_change();
        test_load();
        test_oneshot();
        test_reset_mid();
        test_load_start_stop();
        test_full_modulus();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
